irq_controller: RTL and testbench
=================================

# irq_controller

Interrupt controller consuming the 4-bit `ex_int` vector produced by the verification peripheral (bit 0 GPIO, 1 syscall, 2 invalid, 3 overflow). It edge-detects and latches each source as pending and applies a software mask. A fixed-priority selector picks one source, and the controller runs a request/acknowledge/end-of-interrupt handshake with the CPU. It is also a memory-mapped slave on the data-memory bus, with its word select and write enable driven by the address decoder.

## Interface
- `NSRC`, 4, number of interrupt sources; fixed at 4 for this design.
- `Clk`  in  1  system clock; all state updates on rising edge.
- `Rst`  in  1  synchronous, active-high reset.
- `ex_int`  in  4  interrupt source levels, synchronous to `Clk`.
- `a`  in  2  register word select (`addr_dm[3:2]`).
- `we`  in  1  write enable, pre-qualified by the address decoder.
- `wd`  in  32  write data.
- `rd`  out  32  read data, combinational from `a`; unused bits 0.
- `irq`  out  1  interrupt request to CPU.
- `irq_ack`  in  1  CPU acknowledge, 1-cycle pulse.
- `irq_id`  out  2  ID of requested or in-service source.
- `in_service`  out  1  high while a handler is active.

## Operation
- Register map (`a`):
  - 0 = PEND: bits[3:0] read; write-1-to-clear.
  - 1 = MASK: bits[3:0] read/write; 1 enables the source.
  - 2 = CAUSE: read-only; {26'b0, state[1:0], in_service, irq, irq_id[1:0]}.
  - 3 = EOI: any write ends service; reads 0.
- Edge detect:
  - Register `ex_int` as `prev`.
  - `ex_int & ~prev` sets the PEND bit.
  - A level held high sets PEND only once.
- Set/clear conflict: if a set and a W1C hit the same PEND bit in the same cycle, the set wins.
- Eligible sources: `PEND & MASK`.
- Priority: fixed, highest index wins (3 > 2 > 1 > 0).
- State machine:
  - IDLE: if any source is eligible, latch the winner into `irq_id` and go to REQ.
  - REQ: `irq`=1, and `irq_id` is frozen even if PEND or MASK change. On `irq_ack`, clear PEND[`irq_id`] and go to SVC. Otherwise stay in REQ.
  - SVC: `irq`=0, `in_service`=1. New edges still latch in PEND, but no new request is raised (no nesting). On a write to EOI, go to IDLE.
- Ignored events:
  - `irq_ack` outside REQ.
  - EOI write outside SVC.
- Same-cycle coincidences:
  - ack coinciding with a new edge on the same source: clear due to ack applies first, then the set, so PEND stays 1.
  - EOI coinciding with an eligible source: the controller passes through IDLE for one cycle.
- Reset values:
  - PEND=0, MASK=0, `prev`=0.
  - state=IDLE, `irq_id`=0, `irq`=0, `in_service`=0.
  - `rd` reflects the cleared registers.
- Reset mid-handshake (REQ or SVC) drops straight to IDLE with all state cleared. It does not wait for an ack.

## Timing
- `ex_int` rises before edge n → PEND set after edge n.
- That source eligible → state REQ and `irq`=1 after edge n+1, so request latency is 2 cycles.
- `irq_ack` sampled at edge k → `irq`=0 and `in_service`=1 after edge k.
- EOI write at edge m → IDLE after m. Earliest next `irq` is after m+1.
- MASK/PEND writes take effect at the edge they are sampled. A MASK write affects eligibility from the next cycle.
- Reads are combinational. The value read is the state before the current edge.

## Structure
- Package `irq_pkg`:
  - state enum {IDLE, REQ, SVC}.
  - register offsets PEND/MASK/CAUSE/EOI.
  - source IDs SRC_GPIO=0, SRC_SYSCALL=1, SRC_INVALID=2, SRC_OVERFLOW=3.
- One sub-module: `irq_prio_enc`, a combinational 4→2 highest-index encoder with a `valid` output.

## Test plan
- Basic request:
  - MASK=4'hF, pulse `ex_int`=4'b0100 for 1 cycle → PEND=4'b0100.
  - `irq`=1 two cycles after the edge, `irq_id`=2.
  - ack → PEND=0, `in_service`=1.
  - EOI → IDLE.
- Priority:
  - Raise bits 0 and 3 together with MASK=4'hF → `irq_id`=3.
  - After ack and EOI, a second request with `irq_id`=0 follows.
- Masking:
  - MASK=4'b1110, pulse bit 0 → PEND=4'b0001 and no `irq`.
  - Write MASK=4'hF → `irq`=1 with `irq_id`=0 two cycles later.
- Level source and conflicts:
  - Hold bit 1 high for 10 cycles → PEND[1] set once.
  - W1C PEND=4'b0010 in the same cycle as a fresh edge on bit 1 → PEND[1] stays 1.
- No nesting, and ignored events:
  - During SVC, pulse bit 3 → `irq` stays 0, PEND[3]=1.
  - EOI → `irq`=1 with `irq_id`=3.
  - Stray `irq_ack` in IDLE and an EOI write in REQ change nothing.
- Reset mid-operation: assert `Rst` in REQ with PEND=4'b1010 → next cycle all outputs 0, PEND=0, MASK=0, state IDLE.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: FSM states, register
// offsets and the source ID assignments.
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SVC  = 2'd2
  } irq_state_t;

  localparam logic [1:0] REG_PEND  = 2'd0;
  localparam logic [1:0] REG_MASK  = 2'd1;
  localparam logic [1:0] REG_CAUSE = 2'd2;
  localparam logic [1:0] REG_EOI   = 2'd3;

  localparam logic [1:0] SRC_GPIO     = 2'd0;
  localparam logic [1:0] SRC_SYSCALL  = 2'd1;
  localparam logic [1:0] SRC_INVALID  = 2'd2;
  localparam logic [1:0] SRC_OVERFLOW = 2'd3;

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational 4-to-2 priority encoder; the highest set index wins.
module irq_prio_enc (
  input  logic [3:0] req,
  output logic [1:0] id,
  output logic       valid
);

  always_comb begin
    id    = 2'd0;
    valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (req[i]) begin
        id    = 2'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Edge-triggered, maskable interrupt controller with a single-level
// request/ack/EOI handshake and a small memory-mapped register file.
module irq_controller
  import irq_pkg::*;
#(
  parameter int NSRC = 4
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic [NSRC-1:0] ex_int,
  input  logic [1:0]      a,
  input  logic            we,
  input  logic [31:0]     wd,
  output logic [31:0]     rd,
  output logic            irq,
  input  logic            irq_ack,
  output logic [1:0]      irq_id,
  output logic            in_service
);

  irq_state_t      state_reg;
  logic [NSRC-1:0] pend_reg, pend_next;
  logic [NSRC-1:0] mask_reg;
  logic [NSRC-1:0] prev_reg;
  logic [1:0]      irq_id_reg;
  logic            irq_reg;
  logic            in_service_reg;

  logic [NSRC-1:0] rise, w1c, ack_clr, eligible;
  logic [1:0]      win_id;
  logic            win_valid;
  logic            ack_hit, eoi_wr, mask_wr;
  logic            unused_wd;

  assign unused_wd = ^wd[31:NSRC];

  assign rise     = ex_int & ~prev_reg;
  assign w1c      = (we && a == REG_PEND) ? wd[NSRC-1:0] : '0;
  assign mask_wr  = we && (a == REG_MASK);
  assign eoi_wr   = we && (a == REG_EOI) && (state_reg == SVC);
  assign ack_hit  = irq_ack && (state_reg == REQ);
  assign eligible = pend_reg & mask_reg;

  always_comb begin
    ack_clr = '0;
    if (ack_hit) ack_clr[irq_id_reg] = 1'b1;
  end

  // Clears are applied before sets, so a fresh edge always survives.
  assign pend_next = (pend_reg & ~w1c & ~ack_clr) | rise;

  irq_prio_enc u_prio (
    .req   (eligible),
    .id    (win_id),
    .valid (win_valid)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_reg      <= IDLE;
      pend_reg       <= '0;
      mask_reg       <= '0;
      prev_reg       <= '0;
      irq_id_reg     <= 2'd0;
      irq_reg        <= 1'b0;
      in_service_reg <= 1'b0;
    end else begin
      prev_reg <= ex_int;
      pend_reg <= pend_next;
      if (mask_wr) mask_reg <= wd[NSRC-1:0];

      case (state_reg)
        IDLE: begin
          if (win_valid) begin
            state_reg  <= REQ;
            irq_id_reg <= win_id;
            irq_reg    <= 1'b1;
          end
        end
        REQ: begin
          // irq_id stays frozen here regardless of PEND/MASK activity.
          if (ack_hit) begin
            state_reg      <= SVC;
            irq_reg        <= 1'b0;
            in_service_reg <= 1'b1;
          end
        end
        SVC: begin
          if (eoi_wr) begin
            state_reg      <= IDLE;
            in_service_reg <= 1'b0;
          end
        end
        default: begin
          state_reg      <= IDLE;
          irq_reg        <= 1'b0;
          in_service_reg <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    rd = 32'd0;
    case (a)
      REG_PEND:  rd[NSRC-1:0] = pend_reg;
      REG_MASK:  rd[NSRC-1:0] = mask_reg;
      REG_CAUSE: rd[5:0]      = {state_reg, in_service_reg, irq_reg, irq_id_reg};
      default:   rd           = 32'd0;
    endcase
  end

  assign irq        = irq_reg;
  assign irq_id     = irq_id_reg;
  assign in_service = in_service_reg;

endmodule

// File: tb/tb_irq_controller.sv
// Randomized + directed bench: a driver feeds a rule-level reference model and
// queues expected outputs; a monitor pops and compares one entry per cycle.
module tb_irq_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  ex_int = '0;
  logic [1:0]  a = '0;
  logic        we = 1'b0;
  logic [31:0] wd = '0;
  logic [31:0] rd;
  logic        irq;
  logic        irq_ack = 1'b0;
  logic [1:0]  irq_id;
  logic        in_service;

  always #5 clk = ~clk;

  irq_controller #(.NSRC(4)) dut (
    .Clk        (clk),
    .Rst        (rst),
    .ex_int     (ex_int),
    .a          (a),
    .we         (we),
    .wd         (wd),
    .rd         (rd),
    .irq        (irq),
    .irq_ack    (irq_ack),
    .irq_id     (irq_id),
    .in_service (in_service)
  );

  typedef struct {
    logic        irq;
    logic [1:0]  id;
    logic        insvc;
    logic [31:0] rd;
    int          seq;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   seq_no   = 0;
  bit   running  = 0;

  // Reference model state: 0 = idle, 1 = requesting, 2 = servicing.
  bit m_pend[4];
  bit m_mask[4];
  bit m_prev[4];
  int m_st = 0;
  int m_id = 0;

  task automatic model_step(input logic [3:0] ex, input logic [1:0] aa,
                            input logic wen, input logic [31:0] wdat,
                            input logic ack, input logic r);
    bit np[4];
    bit nm[4];
    int nst, nid;
    exp_t e;
    if (r) begin
      for (int i = 0; i < 4; i++) begin np[i] = 0; nm[i] = 0; m_prev[i] = 0; end
      nst = 0; nid = 0;
    end else begin
      nst = m_st; nid = m_id;
      if (m_st == 0) begin
        for (int i = 3; i >= 0; i--)
          if (nst == 0 && m_pend[i] && m_mask[i]) begin nst = 1; nid = i; end
      end else if (m_st == 1) begin
        if (ack) nst = 2;
      end else begin
        if (wen && aa == 2'd3) nst = 0;
      end
      for (int i = 0; i < 4; i++) begin
        bit rise, clr;
        rise  = ex[i] && !m_prev[i];
        clr   = (wen && aa == 2'd0 && wdat[i]) || (m_st == 1 && ack && m_id == i);
        np[i] = rise ? 1'b1 : (clr ? 1'b0 : m_pend[i]);
        nm[i] = (wen && aa == 2'd1) ? wdat[i] : m_mask[i];
        m_prev[i] = ex[i];
      end
    end
    for (int i = 0; i < 4; i++) begin m_pend[i] = np[i]; m_mask[i] = nm[i]; end
    m_st = nst; m_id = nid;

    e.irq   = (nst == 1);
    e.insvc = (nst == 2);
    e.id    = 2'(nid);
    e.rd    = 32'd0;
    case (aa)
      2'd0: for (int i = 0; i < 4; i++) e.rd[i] = np[i];
      2'd1: for (int i = 0; i < 4; i++) e.rd[i] = nm[i];
      2'd2: e.rd = {26'd0, 2'(nst), e.insvc, e.irq, e.id};
      default: e.rd = 32'd0;
    endcase
    e.seq = seq_no;
    seq_no++;
    sb.push_back(e);
    running = 1;
  endtask

  task automatic step(input logic [3:0] ex, input logic [1:0] aa, input logic wen,
                      input logic [31:0] wdat, input logic ack, input logic r = 1'b0);
    @(negedge clk);
    ex_int = ex; a = aa; we = wen; wd = wdat; irq_ack = ack; rst = r;
    model_step(ex, aa, wen, wdat, ack, r);
  endtask

  task automatic idle(input int n, input logic [1:0] aa);
    for (int i = 0; i < n; i++) step(4'd0, aa, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic wr(input logic [1:0] aa, input logic [31:0] v);
    step(4'd0, aa, 1'b1, v, 1'b0);
  endtask

  task automatic ack_cycle();
    step(4'd0, 2'd0, 1'b0, 32'd0, 1'b1);
  endtask

  // Monitor: every cycle the DUT presents a new output set, one entry is due.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_checks++;
        if (irq !== e.irq) begin
          n_fail++;
          $display("FAIL irq seq=%0d got=%b expected=%b", e.seq, irq, e.irq);
        end
        n_checks++;
        if (irq_id !== e.id) begin
          n_fail++;
          $display("FAIL irq_id seq=%0d got=%0d expected=%0d", e.seq, irq_id, e.id);
        end
        n_checks++;
        if (in_service !== e.insvc) begin
          n_fail++;
          $display("FAIL in_service seq=%0d got=%b expected=%b", e.seq, in_service, e.insvc);
        end
        n_checks++;
        if (rd !== e.rd) begin
          n_fail++;
          $display("FAIL rd seq=%0d a=%0d got=%h expected=%h", e.seq, a, rd, e.rd);
        end
      end else if (running) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard_underflow at time %0t", $time);
      end
    end
  end

  initial begin
    logic [3:0] lvl;
    // Reset
    step(4'd0, 2'd0, 1'b0, 32'd0, 1'b0, 1'b1);
    step(4'd0, 2'd2, 1'b0, 32'd0, 1'b0, 1'b1);
    idle(1, 2'd1);

    // Basic request
    wr(2'd1, 32'hF);
    step(4'b0100, 2'd0, 1'b0, 32'd0, 1'b0);
    idle(1, 2'd0);
    idle(2, 2'd2);
    ack_cycle();
    idle(2, 2'd2);
    wr(2'd3, 32'h0);
    idle(2, 2'd2);

    // Priority
    step(4'b1001, 2'd0, 1'b0, 32'd0, 1'b0);
    idle(3, 2'd2);
    ack_cycle();
    wr(2'd3, 32'h0);
    idle(3, 2'd2);
    ack_cycle();
    wr(2'd3, 32'h0);
    idle(1, 2'd0);

    // Masking
    wr(2'd1, 32'hE);
    step(4'b0001, 2'd0, 1'b0, 32'd0, 1'b0);
    idle(3, 2'd0);
    wr(2'd1, 32'hF);
    idle(3, 2'd2);
    ack_cycle();
    wr(2'd3, 32'h0);

    // Level source and set/clear conflict
    wr(2'd1, 32'h0);
    for (int i = 0; i < 10; i++) step(4'b0010, 2'd0, 1'b0, 32'd0, 1'b0);
    idle(1, 2'd0);
    wr(2'd0, 32'h2);
    step(4'b0010, 2'd0, 1'b1, 32'h2, 1'b0);
    idle(2, 2'd0);

    // No nesting, ignored events
    wr(2'd1, 32'hF);
    idle(2, 2'd2);
    wr(2'd3, 32'h0);
    ack_cycle();
    step(4'b1000, 2'd0, 1'b0, 32'd0, 1'b0);
    idle(3, 2'd2);
    wr(2'd3, 32'h0);
    idle(2, 2'd2);
    ack_cycle();
    wr(2'd3, 32'h0);
    wr(2'd0, 32'hF);
    ack_cycle();
    idle(2, 2'd2);

    // Reset mid-request
    step(4'b1010, 2'd0, 1'b0, 32'd0, 1'b0);
    idle(2, 2'd0);
    step(4'd0, 2'd0, 1'b0, 32'd0, 1'b0, 1'b1);
    idle(1, 2'd0);
    idle(1, 2'd1);
    idle(1, 2'd2);

    // Randomized traffic
    lvl = '0;
    for (int i = 0; i < 3000; i++) begin
      logic [3:0]  flip;
      logic        wen, ack, r;
      logic [1:0]  aa;
      logic [31:0] wdat;
      flip = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
      lvl  = lvl ^ flip;
      aa   = 2'($urandom);
      wen  = ($urandom_range(0, 4) == 0);
      wdat = $urandom;
      ack  = ($urandom_range(0, 2) == 0);
      r    = ($urandom_range(0, 199) == 0);
      step(lvl, aa, wen, wdat, ack, r);
    end

    idle(1, 2'd2);
    @(posedge clk);
    #2;
    running = 0;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_leftover got=%0d expected=0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
